// File: rtl/rx_ctrl_pkg.sv
// Shared types and configuration limits for the serial receiver control unit.
package rx_ctrl_pkg;

    // Frame sequencing states; 3-bit encoding.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        CHECK  = 3'd5,
        LOAD   = 3'd6
    } rx_state_t;

    // Legal frame geometry.
    localparam int DATA_BITS_MIN = 5;
    localparam int DATA_BITS_MAX = 9;
    localparam int STOP_BITS_MIN = 1;
    localparam int STOP_BITS_MAX = 2;

    // True when the requested frame geometry is supported.
    function automatic bit rx_cfg_legal(input int data_bits, input int stop_bits);
        return (data_bits >= DATA_BITS_MIN) && (data_bits <= DATA_BITS_MAX) &&
               (stop_bits >= STOP_BITS_MIN) && (stop_bits <= STOP_BITS_MAX);
    endfunction

endpackage

// File: rtl/rx_bit_counter.sv
// Bit counter shared by the data and stop phases. Wraps to zero on the
// count that matches the rollover value; rollover flag is combinational so
// the controller can act on the same strobe that ends a phase.
module rx_bit_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             i_clear,
    input  logic             i_count_enable,
    input  logic [WIDTH-1:0] i_rollover_val,
    output logic             o_rollover_flag
);

    logic [WIDTH-1:0] r_count;
    logic             w_at_rollover;

    assign w_at_rollover   = (r_count == i_rollover_val);
    assign o_rollover_flag = w_at_rollover;

    // Count enabled strobes; clear has priority, last count wraps to zero.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_count_enable) begin
            r_count <= w_at_rollover ? '0 : r_count + 1'b1;
        end
    end

endmodule

// File: rtl/rx_ctrl_unit.sv
// Receiver control unit: sequences one frame from start detection through
// data, optional parity and stop bits, then loads the receive buffer when
// no framing or parity error was seen.
module rx_ctrl_unit
    import rx_ctrl_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic clk,
    input  logic n_rst,
    input  logic start_bit_detected,
    input  logic bit_strobe,
    input  logic sampled_bit,
    output logic sbc_clear,
    output logic enable_timer,
    output logic shift_enable,
    output logic load_buffer,
    output logic framing_error,
    output logic parity_error,
    output logic rx_busy
);

    localparam int                CNT_W     = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0]  STOP_LAST = CNT_W'(STOP_BITS - 1);
    localparam logic              ODD_BIT   = (PARITY_ODD != 0);
    localparam bit                HAS_PAR   = (PARITY_EN != 0);

    // Reject unsupported frame geometry at elaboration time.
    if (!rx_cfg_legal(DATA_BITS, STOP_BITS)) begin : g_bad_cfg
        $error("rx_ctrl_unit: DATA_BITS must be 5..9 and STOP_BITS 1..2");
    end

    rx_state_t          r_state;
    rx_state_t          w_state_next;
    logic               r_parity_acc;
    logic               r_framing_error;
    logic               r_parity_error;
    logic               w_cnt_clear;
    logic               w_cnt_en;
    logic               w_cnt_last;
    logic [CNT_W-1:0]   w_rollover_val;

    // The counter serves both bit phases; it wraps on the last data bit so
    // the stop phase always starts from zero.
    assign w_cnt_clear    = (r_state == CLEAR);
    assign w_cnt_en       = bit_strobe && ((r_state == DATA) || (r_state == STOP));
    assign w_rollover_val = (r_state == STOP) ? STOP_LAST : DATA_LAST;

    rx_bit_counter #(
        .WIDTH (CNT_W)
    ) u_bit_counter (
        .clk             (clk),
        .n_rst           (n_rst),
        .i_clear         (w_cnt_clear),
        .i_count_enable  (w_cnt_en),
        .i_rollover_val  (w_rollover_val),
        .o_rollover_flag (w_cnt_last)
    );

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode; strobes only matter in the three bit phases.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:   if (start_bit_detected) w_state_next = CLEAR;
            CLEAR:  w_state_next = DATA;
            DATA:   if (bit_strobe && w_cnt_last) w_state_next = HAS_PAR ? PARITY : STOP;
            PARITY: if (bit_strobe) w_state_next = STOP;
            STOP:   if (bit_strobe && w_cnt_last) w_state_next = CHECK;
            CHECK:  w_state_next = (r_framing_error || r_parity_error) ? IDLE : LOAD;
            LOAD:   w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Parity accumulation and sticky error flags, cleared at frame start.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_parity_acc    <= 1'b0;
            r_framing_error <= 1'b0;
            r_parity_error  <= 1'b0;
        end else begin
            case (r_state)
                CLEAR: begin
                    r_parity_acc    <= 1'b0;
                    r_framing_error <= 1'b0;
                    r_parity_error  <= 1'b0;
                end
                DATA: begin
                    if (bit_strobe) r_parity_acc <= r_parity_acc ^ sampled_bit;
                end
                PARITY: begin
                    // Total parity over data plus parity bit must equal the odd/even mode.
                    if (bit_strobe && ((r_parity_acc ^ sampled_bit) != ODD_BIT)) begin
                        r_parity_error <= 1'b1;
                    end
                end
                STOP: begin
                    if (bit_strobe && !sampled_bit) r_framing_error <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign sbc_clear     = (r_state == CLEAR);
    assign enable_timer  = (r_state == DATA) || (r_state == PARITY) || (r_state == STOP);
    assign shift_enable  = (r_state == DATA) && bit_strobe;
    assign load_buffer   = (r_state == LOAD);
    assign rx_busy       = (r_state != IDLE);
    assign framing_error = r_framing_error;
    assign parity_error  = r_parity_error;

endmodule

// File: tb/tb_rx_ctrl_unit.sv
// Bench for rx_ctrl_unit: three frame configurations (8N1, 8E1, 7O2) run
// side by side. A frame-level driver derives the expected output vector for
// each cycle from the frame contents; one negedge process compares all units.
`timescale 1ns/1ps
module tb_rx_ctrl_unit;

    localparam int N = 3;
    // Expected {sbc_clear, enable_timer, shift_enable, load_buffer, rx_busy}
    localparam logic [4:0] E_IDLE  = 5'b00000;
    localparam logic [4:0] E_CLR   = 5'b10001;
    localparam logic [4:0] E_RUN   = 5'b01001;
    localparam logic [4:0] E_SHIFT = 5'b01101;
    localparam logic [4:0] E_CHK   = 5'b00001;
    localparam logic [4:0] E_LOAD  = 5'b00011;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    logic [N-1:0] sbd = '0, stb = '0, sbit = '0;
    logic [N-1:0] o_sbc, o_en, o_sh, o_ld, o_fe, o_pe, o_busy;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_stop_cyc = 0;
    bit chk_en = 1'b0;
    bit fe_m [N];
    bit pe_m [N];
    logic [6:0] exp_v [N];
    int n_shift [N];
    int n_load [N];
    int n_sbc [N];
    int last_load_cyc [N];
    logic [6:0] act_v;

    always #5 clk = ~clk;

    rx_ctrl_unit #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_EN(0), .PARITY_ODD(0)) u_8n1 (
        .clk(clk), .n_rst(n_rst), .start_bit_detected(sbd[0]), .bit_strobe(stb[0]),
        .sampled_bit(sbit[0]), .sbc_clear(o_sbc[0]), .enable_timer(o_en[0]),
        .shift_enable(o_sh[0]), .load_buffer(o_ld[0]), .framing_error(o_fe[0]),
        .parity_error(o_pe[0]), .rx_busy(o_busy[0]));

    rx_ctrl_unit #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_EN(1), .PARITY_ODD(0)) u_8e1 (
        .clk(clk), .n_rst(n_rst), .start_bit_detected(sbd[1]), .bit_strobe(stb[1]),
        .sampled_bit(sbit[1]), .sbc_clear(o_sbc[1]), .enable_timer(o_en[1]),
        .shift_enable(o_sh[1]), .load_buffer(o_ld[1]), .framing_error(o_fe[1]),
        .parity_error(o_pe[1]), .rx_busy(o_busy[1]));

    rx_ctrl_unit #(.DATA_BITS(7), .STOP_BITS(2), .PARITY_EN(1), .PARITY_ODD(1)) u_7o2 (
        .clk(clk), .n_rst(n_rst), .start_bit_detected(sbd[2]), .bit_strobe(stb[2]),
        .sampled_bit(sbit[2]), .sbc_clear(o_sbc[2]), .enable_timer(o_en[2]),
        .shift_enable(o_sh[2]), .load_buffer(o_ld[2]), .framing_error(o_fe[2]),
        .parity_error(o_pe[2]), .rx_busy(o_busy[2]));

    function automatic int db_of(input int i);
        return (i == 2) ? 7 : 8;
    endfunction
    function automatic int sb_of(input int i);
        return (i == 2) ? 2 : 1;
    endfunction
    function automatic bit pe_of(input int i);
        return (i != 0);
    endfunction
    function automatic bit po_of(input int i);
        return (i == 2);
    endfunction
    function automatic bit rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Per-cycle comparison of every unit against the frame-level expectation.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int j = 0; j < N; j++) begin
                act_v = {o_sbc[j], o_en[j], o_sh[j], o_ld[j], o_busy[j], o_fe[j], o_pe[j]};
                total++;
                if (act_v !== exp_v[j]) begin
                    bad++;
                    $display("FAIL cycle_check unit=%0d cyc=%0d got{sbc,en,sh,ld,busy,fe,pe}=%b want=%b",
                             j, cyc, act_v, exp_v[j]);
                end
                if (o_sh[j] === 1'b1) n_shift[j]++;
                if (o_sbc[j] === 1'b1) n_sbc[j]++;
                if (o_ld[j] === 1'b1) begin
                    n_load[j]++;
                    last_load_cyc[j] = cyc;
                end
            end
        end
    end

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    // One clock cycle: active unit gets the given inputs, others idle with strobe noise.
    task automatic step(input int act, input bit a_sbd, input bit a_stb, input bit a_bit,
                        input logic [4:0] a_exp);
        cyc++;
        for (int j = 0; j < N; j++) begin
            if (j == act) begin
                sbd[j] = a_sbd; stb[j] = a_stb; sbit[j] = a_bit;
                exp_v[j] = {a_exp, fe_m[j], pe_m[j]};
            end else begin
                sbd[j] = 1'b0; stb[j] = rb(); sbit[j] = rb();
                exp_v[j] = {E_IDLE, fe_m[j], pe_m[j]};
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(-1, 1'b0, 1'b0, 1'b0, E_IDLE);
    endtask

    task automatic gap(input int i, input bit hold);
        repeat ($urandom_range(0, 2)) step(i, hold ? 1'b1 : rb(), 1'b0, rb(), E_RUN);
    endtask

    // Drive one frame into unit i; abort_after>0 stops after that many data strobes.
    task automatic frame(input int i, input int data, input bit pbit, input bit [1:0] stops,
                         input bit hold, input int abort_after);
        int ones;
        ones = 0;
        step(i, 1'b1, rb(), rb(), E_IDLE);
        step(i, hold ? 1'b1 : rb(), rb(), rb(), E_CLR);
        fe_m[i] = 1'b0;
        pe_m[i] = 1'b0;
        for (int b = 0; b < db_of(i); b++) begin
            gap(i, hold);
            step(i, hold ? 1'b1 : rb(), 1'b1, data[b], E_SHIFT);
            ones += data[b];
            if (b + 1 == abort_after) return;
        end
        if (pe_of(i)) begin
            gap(i, hold);
            step(i, hold ? 1'b1 : rb(), 1'b1, pbit, E_RUN);
            if (((ones + int'(pbit)) % 2) != int'(po_of(i))) pe_m[i] = 1'b1;
        end
        for (int s = 0; s < sb_of(i); s++) begin
            gap(i, hold);
            step(i, hold ? 1'b1 : rb(), 1'b1, stops[s], E_RUN);
            if (!stops[s]) fe_m[i] = 1'b1;
        end
        last_stop_cyc = cyc;
        step(i, hold ? 1'b1 : rb(), rb(), rb(), E_CHK);
        if (!fe_m[i] && !pe_m[i]) step(i, hold ? 1'b1 : rb(), rb(), rb(), E_LOAD);
    endtask

    initial begin
        int s0, l0, c0, ui, data, ones;
        bit pbit;
        bit [1:0] stops;
        for (int j = 0; j < N; j++) begin
            fe_m[j] = 1'b0; pe_m[j] = 1'b0; exp_v[j] = '0;
            n_shift[j] = 0; n_load[j] = 0; n_sbc[j] = 0; last_load_cyc[j] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int j = 0; j < N; j++)
            chk("reset_outputs", int'({o_sbc[j], o_en[j], o_sh[j], o_ld[j], o_busy[j], o_fe[j], o_pe[j]}), 0);
        n_rst = 1'b1;
        chk_en = 1'b1;
        idle(3);

        // 8N1 0xA5, good stop
        s0 = n_shift[0]; l0 = n_load[0];
        frame(0, 'hA5, 1'b0, 2'b11, 1'b0, 0);
        chk("a5_shift_count", n_shift[0] - s0, 8);
        chk("a5_load_count", n_load[0] - l0, 1);
        chk("a5_load_latency", last_load_cyc[0] - last_stop_cyc, 2);
        chk("a5_framing", int'(o_fe[0]), 0);
        chk("a5_parity", int'(o_pe[0]), 0);
        idle(2);

        // 8N1 stop sampled 0, then a good frame
        l0 = n_load[0];
        frame(0, 'h3C, 1'b0, 2'b10, 1'b0, 0);
        chk("badstop_framing", int'(o_fe[0]), 1);
        chk("badstop_no_load", n_load[0] - l0, 0);
        chk("badstop_idle", int'(o_busy[0]), 0);
        idle(3);
        l0 = n_load[0];
        frame(0, 'h5A, 1'b0, 2'b11, 1'b0, 0);
        chk("recover_framing", int'(o_fe[0]), 0);
        chk("recover_load", n_load[0] - l0, 1);
        idle(2);

        // 8E1 data 0x03: parity 1 is wrong, parity 0 is right
        l0 = n_load[1];
        frame(1, 'h03, 1'b1, 2'b11, 1'b0, 0);
        chk("even_bad_parity", int'(o_pe[1]), 1);
        chk("even_bad_no_load", n_load[1] - l0, 0);
        idle(2);
        l0 = n_load[1];
        frame(1, 'h03, 1'b0, 2'b11, 1'b0, 0);
        chk("even_good_parity", int'(o_pe[1]), 0);
        chk("even_good_load", n_load[1] - l0, 1);
        idle(2);

        // 7O2 data 0x35 (four ones, odd parity bit 1): second stop 0, then both good
        l0 = n_load[2];
        frame(2, 'h35, 1'b1, 2'b01, 1'b0, 0);
        chk("2stop_framing", int'(o_fe[2]), 1);
        chk("2stop_no_load", n_load[2] - l0, 0);
        idle(2);
        l0 = n_load[2];
        frame(2, 'h35, 1'b1, 2'b11, 1'b0, 0);
        chk("2stop_good_errs", int'({o_fe[2], o_pe[2]}), 0);
        chk("2stop_good_load", n_load[2] - l0, 1);
        idle(2);

        // Reset after the fourth data strobe
        frame(0, 'hC3, 1'b0, 2'b11, 1'b0, 4);
        chk_en = 1'b0;
        sbd = '0; stb = '0; sbit = '0;
        n_rst = 1'b0;
        #1;
        chk("midframe_reset_outputs",
            int'({o_sbc[0], o_en[0], o_sh[0], o_ld[0], o_busy[0], o_fe[0], o_pe[0]}), 0);
        chk("midframe_reset_busy", int'(o_busy[0]), 0);
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        for (int j = 0; j < N; j++) begin
            fe_m[j] = 1'b0; pe_m[j] = 1'b0;
        end
        chk_en = 1'b1;
        idle(2);
        l0 = n_load[0];
        frame(0, 'h81, 1'b0, 2'b11, 1'b0, 0);
        chk("post_reset_load", n_load[0] - l0, 1);

        // start held high across two back-to-back frames, LOAD included
        c0 = n_sbc[0]; l0 = n_load[0];
        frame(0, 'h96, 1'b0, 2'b11, 1'b1, 0);
        frame(0, 'h69, 1'b0, 2'b11, 1'b1, 0);
        idle(2);
        chk("held_start_clears", n_sbc[0] - c0, 2);
        chk("held_start_loads", n_load[0] - l0, 2);

        // Randomized frames across all three configurations
        for (int k = 0; k < 60; k++) begin
            ui = $urandom_range(0, N - 1);
            data = int'($urandom_range(0, (1 << db_of(ui)) - 1));
            ones = $countones(data);
            pbit = po_of(ui) ? ((ones % 2) == 0) : ((ones % 2) == 1);
            if ($urandom_range(0, 3) == 0) pbit = ~pbit;
            stops[0] = ($urandom_range(0, 6) != 0);
            stops[1] = ($urandom_range(0, 6) != 0);
            frame(ui, data, pbit, stops, ($urandom_range(0, 3) == 0), 0);
            idle($urandom_range(0, 3));
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
